// File: rtl/lebug_reduce_pkg.sv
// Shared op codes and configuration constants for the vector reduce stage.
package lebug_reduce_pkg;

    localparam logic [7:0] OP_PASS = 8'd0;
    localparam logic [7:0] OP_SUM  = 8'd1;
    localparam logic [7:0] OP_MAX  = 8'd2;

    localparam int BYTE_CNT_W = 8;
    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = '1;

endpackage

// File: rtl/reduce_tree_stage.sv
// One registered reduction level: halves the lanes and delays pass-through data and sideband.
// VECTOR_SCALAR_REDUCE_MAX_EN adds a per-node compare path selected by the op.
module reduce_tree_stage
    import lebug_reduce_pkg::*;
#(
    parameter int IN_LANES    = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_TYPE   = 0,
    parameter int PASS_WIDTH  = 256,
    parameter int CHAIN_WIDTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  tracing,
    input  logic                                  valid_in,
    input  logic [7:0]                            op_in,
    input  logic [1:0]                            eof_in,
    input  logic [1:0]                            bof_in,
    input  logic [CHAIN_WIDTH-1:0]                chain_in,
    input  logic [PASS_WIDTH-1:0]                 pass_in,
    input  logic [IN_LANES*DATA_WIDTH-1:0]        lanes_in,
    output logic                                  valid_out,
    output logic [7:0]                            op_out,
    output logic [1:0]                            eof_out,
    output logic [1:0]                            bof_out,
    output logic [CHAIN_WIDTH-1:0]                chain_out,
    output logic [PASS_WIDTH-1:0]                 pass_out,
    output logic [(IN_LANES/2)*DATA_WIDTH-1:0]    lanes_out
);

    localparam int OUT_LANES = IN_LANES / 2;

    if (DATA_TYPE != 0 && DATA_TYPE != 1) begin : g_bad_data_type
        $error("reduce_tree_stage: DATA_TYPE must be 0 or 1");
    end

    logic [OUT_LANES*DATA_WIDTH-1:0] lanes_next;

    for (genvar i = 0; i < OUT_LANES; i++) begin : g_node
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] node;
        assign a = lanes_in[(2*i)*DATA_WIDTH +: DATA_WIDTH];
        assign b = lanes_in[(2*i+1)*DATA_WIDTH +: DATA_WIDTH];
`ifdef VECTOR_SCALAR_REDUCE_MAX_EN
        logic a_gt_b;
        if (DATA_TYPE == 1) begin : g_signed
            assign a_gt_b = $signed(a) > $signed(b);
        end else begin : g_unsigned
            assign a_gt_b = a > b;
        end
        assign node = (op_in == OP_MAX) ? (a_gt_b ? a : b) : a + b;
`else
        assign node = a + b;
`endif
        assign lanes_next[i*DATA_WIDTH +: DATA_WIDTH] = node;
    end

    // Dropping tracing kills in-flight beats; data registers keep moving regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            op_out    <= OP_PASS;
            eof_out   <= '0;
            bof_out   <= '0;
            chain_out <= '0;
            pass_out  <= '0;
            lanes_out <= '0;
        end else begin
            valid_out <= valid_in & tracing;
            op_out    <= op_in;
            eof_out   <= eof_in;
            bof_out   <= bof_in;
            chain_out <= chain_in;
            pass_out  <= pass_in;
            lanes_out <= lanes_next;
        end
    end

endmodule

// File: rtl/vector_scalar_reduce.sv
// Per-chain pass-through or N-lane reduction behind a log2(N)-deep registered tree.
// VECTOR_SCALAR_REDUCE_MAX_EN enables op 2 (max-reduce); otherwise op 2 passes through.
module vector_scalar_reduce
    import lebug_reduce_pkg::*;
#(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 3,
    parameter int DATA_TYPE          = 0,
    parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_OP = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tracing,
    input  logic                          valid_in,
    input  logic [1:0]                    eof_in,
    input  logic [1:0]                    bof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    input  logic [N*DATA_WIDTH-1:0]       vector_in,
    output logic [N*DATA_WIDTH-1:0]       vector_out,
    output logic                          valid_out,
    output logic [1:0]                    eof_out,
    output logic [1:0]                    bof_out,
    output logic [$clog2(MAX_CHAINS)-1:0] chainId_out
);

    // valid_in qualifies one beat per cycle; there is no ready, the pipe never stalls,
    // and valid_out marks the same beat exactly STAGES+1 cycles later.
    localparam int CW       = $clog2(MAX_CHAINS);
    localparam int STAGES   = $clog2(N);
    localparam int VW       = N * DATA_WIDTH;
    localparam int LAST_OFF = 2*N - 2;
    localparam logic [7:0] MY_ID = 8'(PERSONAL_CONFIG_ID);

    logic [7:0]            firmware_op [MAX_CHAINS];
    logic [BYTE_CNT_W-1:0] byte_counter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_counter <= '0;
            for (int i = 0; i < MAX_CHAINS; i++) begin
                firmware_op[i] <= INITIAL_FIRMWARE_OP[8*i +: 8];
            end
        end else if (!tracing) begin
            if (configId == MY_ID) begin
                for (int i = 0; i < MAX_CHAINS; i++) begin
                    if (byte_counter == BYTE_CNT_W'(i)) begin
                        firmware_op[i] <= configData;
                    end
                end
                if (byte_counter != BYTE_CNT_MAX) begin
                    byte_counter <= byte_counter + 1'b1;
                end
            end else begin
                byte_counter <= '0;
            end
        end
    end

    logic          s0_valid;
    logic [7:0]    s0_op;
    logic [1:0]    s0_eof;
    logic [1:0]    s0_bof;
    logic [CW-1:0] s0_chain;
    logic [VW-1:0] s0_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_op    <= OP_PASS;
            s0_eof   <= '0;
            s0_bof   <= '0;
            s0_chain <= '0;
            s0_vec   <= '0;
        end else begin
            s0_valid <= valid_in & tracing;
            s0_op    <= firmware_op[chainId_in];
            s0_eof   <= eof_in;
            s0_bof   <= bof_in;
            s0_chain <= chainId_in;
            s0_vec   <= vector_in;
        end
    end

    // Level k of the tree starts at lane offset 2N - 2*(N>>k) inside tree_bus.
    logic [(2*N-1)*DATA_WIDTH-1:0] tree_bus;
    logic                          valid_bus [STAGES+1];
    logic [7:0]                    op_bus    [STAGES+1];
    logic [1:0]                    eof_bus   [STAGES+1];
    logic [1:0]                    bof_bus   [STAGES+1];
    logic [CW-1:0]                 chain_bus [STAGES+1];
    logic [VW-1:0]                 pass_bus  [STAGES+1];

    assign tree_bus[0 +: VW] = s0_vec;
    assign valid_bus[0]      = s0_valid;
    assign op_bus[0]         = s0_op;
    assign eof_bus[0]        = s0_eof;
    assign bof_bus[0]        = s0_bof;
    assign chain_bus[0]      = s0_chain;
    assign pass_bus[0]       = s0_vec;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LANES_IN = N >> k;
        localparam int OFF_IN   = 2*N - 2*LANES_IN;
        localparam int OFF_OUT  = OFF_IN + LANES_IN;

        reduce_tree_stage #(
            .IN_LANES    (LANES_IN),
            .DATA_WIDTH  (DATA_WIDTH),
            .DATA_TYPE   (DATA_TYPE),
            .PASS_WIDTH  (VW),
            .CHAIN_WIDTH (CW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .tracing   (tracing),
            .valid_in  (valid_bus[k]),
            .op_in     (op_bus[k]),
            .eof_in    (eof_bus[k]),
            .bof_in    (bof_bus[k]),
            .chain_in  (chain_bus[k]),
            .pass_in   (pass_bus[k]),
            .lanes_in  (tree_bus[OFF_IN*DATA_WIDTH +: LANES_IN*DATA_WIDTH]),
            .valid_out (valid_bus[k+1]),
            .op_out    (op_bus[k+1]),
            .eof_out   (eof_bus[k+1]),
            .bof_out   (bof_bus[k+1]),
            .chain_out (chain_bus[k+1]),
            .pass_out  (pass_bus[k+1]),
            .lanes_out (tree_bus[OFF_OUT*DATA_WIDTH +: (LANES_IN/2)*DATA_WIDTH])
        );
    end

    logic [DATA_WIDTH-1:0] scalar;
    logic                  take_reduce;

    assign scalar = tree_bus[LAST_OFF*DATA_WIDTH +: DATA_WIDTH];

`ifdef VECTOR_SCALAR_REDUCE_MAX_EN
    assign take_reduce = (op_bus[STAGES] == OP_SUM) || (op_bus[STAGES] == OP_MAX);
`else
    assign take_reduce = (op_bus[STAGES] == OP_SUM);
`endif

    assign vector_out  = take_reduce ? {{(VW-DATA_WIDTH){1'b0}}, scalar} : pass_bus[STAGES];
    assign valid_out   = valid_bus[STAGES] & tracing;
    assign eof_out     = eof_bus[STAGES];
    assign bof_out     = bof_bus[STAGES];
    assign chainId_out = chain_bus[STAGES];

endmodule

// File: tb/tb_vector_scalar_reduce.sv
// Bench for vector_scalar_reduce: 32-bit unsigned instance plus an 8-bit signed instance.
// Build with or without VECTOR_SCALAR_REDUCE_MAX_EN; expectations follow the macro.
module tb_vector_scalar_reduce;

  localparam int N  = 8;
  localparam int VW = N * 32;
  localparam int EW = VW + 6;

  typedef struct {
    logic [1:0]    ch;
    logic [1:0]    eof;
    logic [1:0]    bof;
    logic [VW-1:0] vec;
    logic [VW-1:0] exp;
  } row_t;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          tracing;
  logic          valid_in;
  logic [1:0]    eof_in, bof_in;
  logic [1:0]    chainId_in;
  logic [7:0]    configId, configData;
  logic [VW-1:0] vector_in;
  logic [VW-1:0] vector_out;
  logic          valid_out;
  logic [1:0]    eof_out, bof_out, chainId_out;

  logic          v8_valid;
  logic [1:0]    v8_eof, v8_bof, v8_chain;
  logic [63:0]   v8_vec;
  logic [63:0]   v8_out;
  logic          v8_valid_out;
  logic [1:0]    v8_eof_out, v8_bof_out, v8_chain_out;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vector_scalar_reduce #(
    .N(N), .DATA_WIDTH(32), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(3),
    .DATA_TYPE(0), .INITIAL_FIRMWARE_OP(32'h0002_0100)
  ) dut (
    .clk(clk), .rst(rst), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
    .configId(configId), .configData(configData), .vector_in(vector_in),
    .vector_out(vector_out), .valid_out(valid_out), .eof_out(eof_out),
    .bof_out(bof_out), .chainId_out(chainId_out)
  );

  vector_scalar_reduce #(
    .N(N), .DATA_WIDTH(8), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(5),
    .DATA_TYPE(1), .INITIAL_FIRMWARE_OP(32'h0002_0100)
  ) dut8 (
    .clk(clk), .rst(rst), .tracing(tracing), .valid_in(v8_valid),
    .eof_in(v8_eof), .bof_in(v8_bof), .chainId_in(v8_chain),
    .configId(configId), .configData(configData), .vector_in(v8_vec),
    .vector_out(v8_out), .valid_out(v8_valid_out), .eof_out(v8_eof_out),
    .bof_out(v8_bof_out), .chainId_out(v8_chain_out)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  int            iss_q[$];
  int            ops[4];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: sum is modulo 2^32, max is unsigned over all lanes, result in lane 0.
  function automatic logic [VW-1:0] model(input int op, input logic [VW-1:0] v);
    logic [VW-1:0]   r;
    longint unsigned acc;
    logic [31:0]     best;
    r = v;
    if (op == 1) begin
      acc = 0;
      for (int i = 0; i < N; i++) acc += longint'(v[i*32 +: 32]);
      acc = acc % 64'h1_0000_0000;
      r = '0;
      r[31:0] = acc[31:0];
    end
`ifdef VECTOR_SCALAR_REDUCE_MAX_EN
    else if (op == 2) begin
      best = v[31:0];
      for (int i = 1; i < N; i++) if (v[i*32 +: 32] > best) best = v[i*32 +: 32];
      r = '0;
      r[31:0] = best;
    end
`endif
    return r;
  endfunction

  function automatic logic [VW-1:0] pack8(input int unsigned l [8]);
    logic [VW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = l[i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got valid_out=1 with chain %0d expected no beat", chainId_out);
      end else begin
        logic [EW-1:0] e;
        int t;
        e = exp_q.pop_front();
        t = iss_q.pop_front();
        check("beat", {chainId_out, bof_out, eof_out, vector_out}, e);
        check_int("latency", cyc - t, 4);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic cfg(input logic [7:0] id, input logic [7:0] d);
    valid_in   = 1'b0;
    tracing    = 1'b0;
    configId   = id;
    configData = d;
    tick();
  endtask

  task automatic send(input logic [1:0] ch, input logic [VW-1:0] v, input logic [1:0] e,
                      input logic [1:0] b, input logic [VW-1:0] expv, input bit expect_out);
    valid_in   = 1'b1;
    chainId_in = ch;
    vector_in  = v;
    eof_in     = e;
    bof_in     = b;
    if (expect_out) begin
      exp_q.push_back({ch, b, e, expv});
      iss_q.push_back(cyc);
    end
    tick();
  endtask

  task automatic send_rand(input int count);
    logic [1:0]    ch;
    logic [VW-1:0] v;
    for (int n = 0; n < count; n++) begin
      ch = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) v[i*32 +: 32] = $urandom();
      if ($urandom_range(0, 3) == 0) v[63:0] = {32'hFFFF_FFFF, 32'h8000_0000};
      send(ch, v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), model(ops[ch], v), 1'b1);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(1);
  endtask

  task automatic run8(input string name, input logic [1:0] ch, input logic [63:0] v,
                      input logic [63:0] expv);
    bit found;
    v8_valid = 1'b1;
    v8_chain = ch;
    v8_vec   = v;
    tick();
    v8_valid = 1'b0;
    found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (v8_valid_out) begin
        found = 1'b1;
        check(name, EW'(v8_out), EW'(expv));
        check_int({name, "_latency"}, i, 4);
      end
    end
    if (!found) check_int({name, "_timeout"}, 0, 1);
    tick();
  endtask

  // ---------------- test ----------------
  row_t tbl[6];

  task automatic set_row(input int idx, input logic [1:0] ch, input logic [1:0] e,
                         input logic [1:0] b, input logic [VW-1:0] v, input logic [VW-1:0] x);
    tbl[idx].ch  = ch;
    tbl[idx].eof = e;
    tbl[idx].bof = b;
    tbl[idx].vec = v;
    tbl[idx].exp = x;
  endtask

  initial begin
    set_row(0, 2'd0, 2'b00, 2'b10, pack8('{1, 2, 3, 4, 5, 6, 7, 8}),
            pack8('{36, 0, 0, 0, 0, 0, 0, 0}));
    set_row(1, 2'd2, 2'b00, 2'b00, pack8('{10, 11, 12, 13, 14, 15, 16, 17}),
            pack8('{10, 11, 12, 13, 14, 15, 16, 17}));
    set_row(2, 2'd3, 2'b01, 2'b00, pack8('{100, 200, 300, 400, 500, 600, 700, 800}),
            pack8('{3600, 0, 0, 0, 0, 0, 0, 0}));
    set_row(3, 2'd3, 2'b00, 2'b00,
            pack8('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}),
            pack8('{32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0, 0}));
`ifdef VECTOR_SCALAR_REDUCE_MAX_EN
    set_row(4, 2'd1, 2'b10, 2'b01, pack8('{5, 32'h8000_0000, 7, 1, 2, 3, 4, 6}),
            pack8('{32'h8000_0000, 0, 0, 0, 0, 0, 0, 0}));
`else
    set_row(4, 2'd1, 2'b10, 2'b01, pack8('{5, 32'h8000_0000, 7, 1, 2, 3, 4, 6}),
            pack8('{5, 32'h8000_0000, 7, 1, 2, 3, 4, 6}));
`endif
    set_row(5, 2'd2, 2'b11, 2'b11, pack8('{9, 8, 7, 6, 5, 4, 3, 2}),
            pack8('{9, 8, 7, 6, 5, 4, 3, 2}));

    rst = 1'b1; tracing = 1'b0; valid_in = 1'b0; eof_in = '0; bof_in = '0;
    chainId_in = '0; configId = '0; configData = '0; vector_in = '0;
    v8_valid = 1'b0; v8_eof = '0; v8_bof = '0; v8_chain = '0; v8_vec = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", {chainId_out, bof_out, eof_out, vector_out}, '0);
    check("reset_valid", EW'(valid_out), '0);
    check("reset_dut8", EW'({v8_valid_out, v8_chain_out, v8_bof_out, v8_eof_out, v8_out}), '0);
    tick();
    rst = 1'b0;
    tick();

    // Five bytes to this block; the fifth lands past the last chain and is dropped.
    cfg(8'd3, 8'd1); cfg(8'd3, 8'd2); cfg(8'd3, 8'd0); cfg(8'd3, 8'd1); cfg(8'd3, 8'hAA);
    cfg(8'd0, 8'd0);
    ops = '{1, 2, 0, 1};
    tracing = 1'b1;

    for (int r = 0; r < 6; r++) begin
      send(tbl[r].ch, tbl[r].vec, tbl[r].eof, tbl[r].bof, tbl[r].exp, 1'b1);
    end
    idle(1);
    send_rand(40);
    idle(8);
    check_int("drain_after_table", exp_q.size(), 0);

    // Foreign configId in between must restart the byte count at chain 0.
    cfg(8'd3, 8'd1); cfg(8'd3, 8'd1); cfg(8'd7, 8'd9); cfg(8'd3, 8'd0); cfg(8'd0, 8'd0);
    ops = '{0, 1, 0, 1};
    tracing = 1'b1;
    send(2'd0, pack8('{1, 2, 3, 4, 5, 6, 7, 8}), 2'b00, 2'b00,
         pack8('{1, 2, 3, 4, 5, 6, 7, 8}), 1'b1);
    send(2'd1, pack8('{1, 1, 1, 1, 1, 1, 1, 1}), 2'b00, 2'b00,
         pack8('{8, 0, 0, 0, 0, 0, 0, 0}), 1'b1);
    idle(1);
    send_rand(20);
    idle(8);
    check_int("drain_after_reconfig", exp_q.size(), 0);

    // Beats in flight when tracing drops, plus valid_in held high during config mode.
    send(2'd1, pack8('{3, 3, 3, 3, 3, 3, 3, 3}), 2'b01, 2'b01, '0, 1'b0);
    send(2'd0, pack8('{4, 4, 4, 4, 4, 4, 4, 4}), 2'b01, 2'b01, '0, 1'b0);
    tracing = 1'b0;
    configId = 8'd0;
    valid_in = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("valid_masked", EW'(valid_out), '0);
    tick();
    valid_in = 1'b0;
    tracing = 1'b1;
    idle(8);
    check_int("no_beats_after_flush", exp_q.size(), 0);

    run8("dt8_sum_wrap", 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00F8);
    run8("dt8_pass", 2'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
`ifdef VECTOR_SCALAR_REDUCE_MAX_EN
    run8("dt8_max_neg", 2'd2, 64'hFAFC_F7FD_FEF9_FFFB, 64'h0000_0000_0000_00FF);
    run8("dt8_max_sign", 2'd2, 64'h8182_8384_8586_7F80, 64'h0000_0000_0000_007F);
`else
    run8("dt8_max_neg", 2'd2, 64'hFAFC_F7FD_FEF9_FFFB, 64'hFAFC_F7FD_FEF9_FFFB);
    run8("dt8_max_sign", 2'd2, 64'h8182_8384_8586_7F80, 64'h8182_8384_8586_7F80);
`endif

    // Reset while three beats are in flight: none may emerge afterwards.
    send(2'd1, pack8('{1, 2, 3, 4, 5, 6, 7, 8}), 2'b01, 2'b10, '0, 1'b0);
    send(2'd3, pack8('{2, 2, 2, 2, 2, 2, 2, 2}), 2'b10, 2'b01, '0, 1'b0);
    send(2'd0, pack8('{7, 7, 7, 7, 7, 7, 7, 7}), 2'b11, 2'b11, '0, 1'b0);
    rst = 1'b1;
    valid_in = 1'b0;
    vector_in = '0;
    chainId_in = '0;
    eof_in = '0;
    bof_in = '0;
    @(negedge clk);
    check("midreset_outputs", {chainId_out, bof_out, eof_out, vector_out}, '0);
    repeat (2) tick();
    rst = 1'b0;
    idle(6);
    @(negedge clk);
    check("post_reset_outputs", {chainId_out, bof_out, eof_out, vector_out}, '0);
    check("post_reset_valid", EW'(valid_out), '0);
    tick();

    // Firmware ops are back to the reset table {0,1,2,0}.
    ops = '{0, 1, 2, 0};
    send(2'd3, pack8('{1, 1, 1, 1, 1, 1, 1, 1}), 2'b00, 2'b00,
         pack8('{1, 1, 1, 1, 1, 1, 1, 1}), 1'b1);
    send(2'd1, pack8('{1, 1, 1, 1, 1, 1, 1, 1}), 2'b00, 2'b00,
         pack8('{8, 0, 0, 0, 0, 0, 0, 0}), 1'b1);
    idle(1);
    send_rand(20);
    idle(8);
    check_int("drain_final", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
